blake2b_block_packer: RTL

Upstream feeder for the BLAKE2b-512 core. It accepts a message as a byte stream with a valid/ready handshake and packs it into 128-byte blocks. It tracks the cumulative byte count and drives the core's `init_512`/`next_512`/`final`/`block`/`length_512` command interface, pacing itself on `ready_512`. A fill buffer and an output buffer let the next block fill while the core processes the current one.

---
 rtl/blake2b_block_packer_if.sv | 41 ++++
 rtl/blake2b_block_packer.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/blake2b_block_packer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface : blake2b_block_packer_if                                        |
// | Purpose   : Groups the byte-stream handshake and the BLAKE2b-512 core      |
// |             command bus used by blake2b_block_packer.                      |
// | Signals   : s_data/s_valid/s_last/s_empty/s_ready - message byte stream    |
// |             init_512/next_512/final_512/block/length_512/ready_512 - core  |
// |             msg_sent - pulse when the final command of a message issues    |
// | Modports  : slave  - the packer (consumes stream, drives core commands)    |
// |             master - the environment (drives stream, models the core)      |
// | Note      : the core's "final" flag is carried as final_512 because        |
// |             "final" is a reserved word in SystemVerilog.                   |
// | Revision  : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
interface blake2b_block_packer_if #(
  parameter int LEN_W = 128
);
  logic [7:0]       s_data;
  logic             s_valid;
  logic             s_last;
  logic             s_empty;
  logic             s_ready;
  logic             init_512;
  logic             next_512;
  logic             final_512;
  logic [1023:0]    block;
  logic [LEN_W-1:0] length_512;
  logic             ready_512;
  logic             msg_sent;

  modport slave (
    input  s_data, s_valid, s_last, s_empty, ready_512,
    output s_ready, init_512, next_512, final_512, block, length_512, msg_sent
  );

  modport master (
    output s_data, s_valid, s_last, s_empty, ready_512,
    input  s_ready, init_512, next_512, final_512, block, length_512, msg_sent
  );
endinterface
`default_nettype wire

// File: rtl/blake2b_block_packer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module    : blake2b_block_packer                                           |
// | Purpose   : Packs a valid/ready byte stream into 128-byte BLAKE2b blocks   |
// |             and drives the BLAKE2b-512 core command interface. A fill      |
// |             buffer and an output buffer let the next block fill while the  |
// |             core works on the current one.                                 |
// | Ports     : clk      - clock, rising edge                                  |
// |             reset_n  - asynchronous active-low reset                       |
// |             bus      - blake2b_block_packer_if.slave (stream + core bus)   |
// | Params    : LEN_W    - width of byte counter and length_512                |
// | Macro     : BLAKE2B_PACKER_LE_EN - defined: byte i at block[8*i+:8]        |
// |             (little-endian); undefined: byte i at block[1023-8*i-:8].      |
// | Revision  : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
module blake2b_block_packer #(
  parameter int LEN_W = 128
) (
  input  wire logic             clk,
  input  wire logic             reset_n,
  blake2b_block_packer_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PEND  = 2'd1,
    ST_GUARD = 2'd2,
    ST_BUSY  = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic [7:0]       r_fcnt;      // fill write index, 0..128
  logic [1023:0]    r_fill;
  logic [LEN_W-1:0] r_bcnt;
  logic             r_lock;      // last byte taken, final command not yet issued
  logic             r_first;
  logic             r_fin_pend;  // fill holds a complete final block awaiting output side
  logic             r_final;
  logic [1023:0]    r_block;
  logic [LEN_W-1:0] r_length;

  // Bit offset of byte slot idx inside a block.
  function automatic logic [9:0] byte_lsb(input logic [6:0] idx);
`ifdef BLAKE2B_PACKER_LE_EN
    byte_lsb = {idx, 3'b000};
`else
    byte_lsb = 10'd1016 - {idx, 3'b000};
`endif
  endfunction

  logic             w_full;
  logic             w_out_free;
  logic             w_s_ready;
  logic             w_acc;
  logic             w_byte;
  logic             w_full_xfer;
  logic             w_last_xfer;
  logic             w_pend_xfer;
  logic             w_xfer;
  logic             w_issue;
  logic [LEN_W-1:0] w_bcnt_inc;
  logic [1023:0]    w_fill_ins;
  logic [1023:0]    w_fill_b;

  assign w_full      = r_fcnt[7];
  // Output side can take a block now: idle, or finishing BUSY this very cycle.
  assign w_out_free  = (r_state == ST_IDLE) | ((r_state == ST_BUSY) & bus.ready_512);
  assign w_s_ready   = ~r_lock & (~w_full | w_out_free);
  assign w_acc       = bus.s_valid & w_s_ready;
  // An empty-message marker carries no data byte.
  assign w_byte      = w_acc & ~(bus.s_last & bus.s_empty);
  // FULL block leaves as non-final once the next byte proves more data follows.
  assign w_full_xfer = w_acc & w_full;
  assign w_last_xfer = w_acc & ~w_full & bus.s_last & w_out_free;
  assign w_pend_xfer = r_fin_pend & w_out_free;
  assign w_xfer      = w_full_xfer | w_last_xfer | w_pend_xfer;
  assign w_issue     = (r_state == ST_PEND) & bus.ready_512;
  assign w_bcnt_inc  = r_bcnt + {{(LEN_W-1){1'b0}}, w_byte};

  // Fill contents with the current byte merged at fcnt, and a fresh fill
  // holding only the current byte at slot 0 (used when a FULL block leaves).
  always_comb begin
    w_fill_ins = r_fill;
    w_fill_b   = '0;
    if (w_byte && !w_full) begin
      w_fill_ins[byte_lsb(r_fcnt[6:0]) +: 8] = bus.s_data;
    end
    if (w_byte) begin
      w_fill_b[byte_lsb(7'd0) +: 8] = bus.s_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_fcnt     <= '0;
      r_fill     <= '0;
      r_bcnt     <= '0;
      r_lock     <= 1'b0;
      r_first    <= 1'b1;
      r_fin_pend <= 1'b0;
      r_final    <= 1'b0;
      r_block    <= '0;
      r_length   <= '0;
    end else begin
      if (w_xfer) begin
        r_block  <= w_full_xfer ? r_fill : w_fill_ins;
        r_length <= w_full_xfer ? r_bcnt : w_bcnt_inc;
        r_final  <= ~w_full_xfer;
      end

      if (w_full_xfer) begin
        r_fill     <= w_fill_b;
        r_fcnt     <= {7'd0, w_byte};
        r_bcnt     <= w_bcnt_inc;
        r_fin_pend <= bus.s_last;
      end else if (w_xfer) begin
        // Final block left: fill restarts zeroed for the next message.
        r_fill     <= '0;
        r_fcnt     <= '0;
        r_bcnt     <= '0;
        r_fin_pend <= 1'b0;
      end else if (w_acc) begin
        r_fill <= w_fill_ins;
        r_fcnt <= r_fcnt + {7'd0, w_byte};
        r_bcnt <= w_bcnt_inc;
        if (bus.s_last) begin
          r_fin_pend <= 1'b1;
        end
      end

      if (w_acc && bus.s_last) begin
        r_lock <= 1'b1;
      end else if (w_issue && r_final) begin
        r_lock <= 1'b0;
      end

      if (w_issue) begin
        r_first <= r_final;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_xfer) w_state_nxt = ST_PEND;
      ST_PEND:  if (bus.ready_512) w_state_nxt = ST_GUARD;
      // The core drops ready one cycle after sampling a command.
      ST_GUARD: w_state_nxt = ST_BUSY;
      ST_BUSY:  if (bus.ready_512) w_state_nxt = w_xfer ? ST_PEND : ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  assign bus.s_ready    = w_s_ready;
  assign bus.init_512   = w_issue & r_first;
  assign bus.next_512   = w_issue & ~r_first;
  assign bus.final_512  = (r_state == ST_PEND) & r_final;
  assign bus.block      = r_block;
  assign bus.length_512 = r_length;
  assign bus.msg_sent   = w_issue & r_final;

endmodule
`default_nettype wire
